// File: rtl/inst_sequencer.sv
// inst_sequencer: fetches instruction words, splits opcode/parameter fields and dispatches DENSE/ACT/COST ops to execution units
// Ports:
//   clk, rst (async, active-high)
//   start      : begin at address 0 (honoured only when idle)
//   abort      : return to idle on the next edge, no done pulse
//   loop_count : iteration count loaded on accepted start (SEQ_LOOP_EN builds only)
//   imem_en, imem_addr, imem_data : synchronous instruction memory read port (data one cycle after enable)
//   issue_valid, issue_unit, issue_param, issue_ready : dispatch handshake (unit 1=dense, 2=act, 3=cost)
//   unit_done  : completion pulse from the issued unit
//   busy, done, err : status (done is a one-cycle pulse, err is sticky until the next accepted start)
// Optional feature: define SEQ_LOOP_EN to enable opcode 4 (LOOP) and the loop counter.
module inst_sequencer #(
  parameter int OP_SIZE = 4,
  parameter int PARAM_A = 4,
  parameter int PARAM_B = 4,
  parameter int ADDR_W = 8,
  localparam int PARAM_C = PARAM_A + PARAM_B,
  localparam int CODE_W = OP_SIZE + PARAM_C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        loop_count,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [CODE_W-1:0]  imem_data,
  output logic               issue_valid,
  output logic [1:0]         issue_unit,
  output logic [PARAM_C-1:0] issue_param,
  input  logic               issue_ready,
  input  logic               unit_done,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [OP_SIZE-1:0] OP_NOP   = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_DENSE = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_ACT   = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_COST  = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_HALT  = OP_SIZE'(15);
  logic [2:0]          state;
  logic [ADDR_W-1:0]   pc;
  logic [CODE_W-1:0]   ir;
  logic [OP_SIZE-1:0]  op;
  logic [OP_SIZE-1:0]  ir_op;
  logic                dispatch;
  assign op       = imem_data[CODE_W-1 -: OP_SIZE];
  assign ir_op    = ir[CODE_W-1 -: OP_SIZE];
  assign dispatch = op == OP_DENSE || op == OP_ACT || op == OP_COST;
  assign imem_en     = state == S_FETCH;
  assign imem_addr   = pc;
  assign issue_valid = state == S_ISSUE;
  assign busy        = state != S_IDLE;
  // Dispatch fields come from the latched instruction so they stay stable while ISSUE waits.
  assign issue_unit  = ir_op == OP_DENSE ? 2'd1 : ir_op == OP_ACT ? 2'd2 : ir_op == OP_COST ? 2'd3 : 2'd0;
  assign issue_param = ir_op == OP_DENSE ? PARAM_C'(ir[PARAM_B-1:0]) :
                       ir_op == OP_ACT   ? PARAM_C'(ir[PARAM_C-1 -: PARAM_A]) :
                       ir_op == OP_COST  ? ir[PARAM_C-1:0] : '0;
`ifdef SEQ_LOOP_EN
  localparam logic [OP_SIZE-1:0] OP_LOOP = OP_SIZE'(4);
  logic [15:0] loop_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) loop_cnt <= '0;
    else if (!abort && state == S_IDLE && start) loop_cnt <= loop_count;
    else if (!abort && state == S_DECODE && op == OP_LOOP && loop_cnt != '0) loop_cnt <= loop_cnt - 1'b1;
`else
  logic unused_loop;
  assign unused_loop = ^loop_count;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) state <= S_IDLE;
      else
        case (state)
          S_IDLE:
            if (start) begin
              pc    <= '0;
              err   <= 1'b0;
              state <= S_FETCH;
            end
          S_FETCH: state <= S_DECODE;
          S_DECODE: begin
            ir <= imem_data;
            if (op == OP_NOP) begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end else if (dispatch) state <= S_ISSUE;
`ifdef SEQ_LOOP_EN
            else if (op == OP_LOOP) begin
              pc    <= loop_cnt != '0 ? ADDR_W'(imem_data[PARAM_C-1:0]) : pc + 1'b1;
              state <= S_FETCH;
            end
`endif
            else begin
              // HALT and illegal opcodes both end the program; only illegal ones flag err.
              err   <= err | (op != OP_HALT);
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_ISSUE: if (issue_ready) state <= S_EXEC;
          S_EXEC:
            if (unit_done) begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: scoreboard bench for inst_sequencer with directed programs
module tb_inst_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, abort, issue_ready, unit_done;
  logic [15:0] loop_count;
  logic        imem_en, issue_valid, busy, done, err;
  logic [7:0]  imem_addr;
  logic [11:0] imem_data;
  logic [1:0]  issue_unit;
  logic [7:0]  issue_param;
  logic [11:0] mem [256];
  int passed = 0, total = 0;
  int exp_unit[$], exp_param[$], exp_derr[$], exp_dpc[$];
  int busy_cyc = 0, done_cnt = 0, nf = 0;
  int addrs [300];
  int ready_delay = 0, done_delay = 3, rcnt = 0, exec_cnt = 0;
  bit spur = 0, idle_spur = 0, hs = 0, prev_valid = 0;
  int prev_unit = 0, prev_param = 0;

  inst_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_count(loop_count),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_param(issue_param),
    .issue_ready(issue_ready), .unit_done(unit_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input logic [11:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic push_iss(input int u, input int p);
    exp_unit.push_back(u);
    exp_param.push_back(p);
  endtask

  task automatic push_done(input int e, input int p);
    exp_derr.push_back(e);
    exp_dpc.push_back(p);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_fetch", imem_en, 1);
    chk("start_err_clear", err, 0);
  endtask

  task automatic run_prog(input int exp_busy);
    int d0, n;
    busy_cyc = 0;
    d0 = done_cnt;
    n = 0;
    do_start();
    while (done_cnt == d0 && n < 500) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
    tick();
    chk("busy_cycles", busy_cyc, exp_busy);
  endtask

  // Unit model: raises ready after ready_delay ISSUE cycles, pulses unit_done done_delay cycles after accept.
  initial begin
    issue_ready = 1'b0;
    unit_done = 1'b0;
    forever begin
      tick();
      unit_done = 1'b0;
      if (rst) begin
        exec_cnt = 0;
        rcnt = 0;
        issue_ready = 1'b0;
      end else begin
        if (idle_spur) begin
          unit_done = 1'b1;
          idle_spur = 0;
        end
        if (hs) begin
          issue_ready = 1'b0;
          rcnt = 0;
          exec_cnt = done_delay;
        end else if (exec_cnt > 0) begin
          exec_cnt--;
          if (exec_cnt == 0) unit_done = 1'b1;
        end
        if (!issue_valid) rcnt = 0;
        else if (!issue_ready) begin
          if (rcnt >= ready_delay) begin
            issue_ready = 1'b1;
            if (spur) unit_done = 1'b1;
          end else rcnt++;
        end
      end
    end
  end

  // Monitor: compares dispatches and done pulses against the expectation queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      hs = 0;
    end else begin
      if (busy) busy_cyc++;
      if (imem_en) begin
        if (nf < 300) addrs[nf] = imem_addr;
        nf++;
      end
      if (issue_valid && prev_valid) begin
        chk("hold_unit", issue_unit, prev_unit);
        chk("hold_param", issue_param, prev_param);
      end
      prev_valid = issue_valid && !issue_ready;
      prev_unit = issue_unit;
      prev_param = issue_param;
      hs = issue_valid && issue_ready;
      if (hs) begin
        chk("dispatch_expected", exp_unit.size() > 0, 1);
        if (exp_unit.size() > 0) begin
          chk("dispatch_unit", issue_unit, exp_unit.pop_front());
          chk("dispatch_param", issue_param, exp_param.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_expected", exp_derr.size() > 0, 1);
        if (exp_derr.size() > 0) begin
          chk("done_err", err, exp_derr.pop_front());
          chk("done_pc", imem_addr, exp_dpc.pop_front());
          chk("done_busy", busy, 0);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    loop_count = 16'd0;
    fill(12'hF00);
    #1 rst = 1'b1;
    #1;
    chk("rst_imem_en", imem_en, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_unit", issue_unit, 0);
    chk("rst_issue_param", issue_param, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    // Basic program
    fill(12'hF00);
    mem[0] = 12'h103; mem[1] = 12'h250; mem[2] = 12'h32A; mem[3] = 12'hF00;
    push_iss(1, 8'h03); push_iss(2, 8'h05); push_iss(3, 8'h2A);
    push_done(0, 3);
    run_prog(23);
    chk("basic_busy_after", busy, 0);
    // Handshake hold for 5 cycles
    ready_delay = 5;
    fill(12'hF00);
    mem[0] = 12'h103;
    push_iss(1, 8'h03);
    push_done(0, 1);
    run_prog(14);
    ready_delay = 0;
    // Illegal opcode at address 2, then a fresh start clears err
    fill(12'hF00);
    mem[0] = 12'h000; mem[1] = 12'h000; mem[2] = 12'h700;
    push_done(1, 2);
    run_prog(6);
    chk("illegal_err_sticky", err, 1);
    fill(12'hF00);
    push_done(0, 0);
    run_prog(2);
    // unit_done during the accepting ISSUE cycle must not finish the op
    spur = 1;
    mem[0] = 12'h103;
    push_iss(1, 8'h03);
    push_done(0, 1);
    run_prog(9);
    spur = 0;
    // unit_done while idle
    idle_spur = 1;
    tick();
    tick();
    chk("idle_spur_busy", busy, 0);
    chk("idle_spur_fetch", imem_en, 0);
    // Loop program
    loop_count = 16'd2;
    fill(12'hF00);
    mem[0] = 12'h101; mem[1] = 12'h400; mem[2] = 12'hF00;
`ifdef SEQ_LOOP_EN
    push_iss(1, 8'h01); push_iss(1, 8'h01); push_iss(1, 8'h01);
    push_done(0, 2);
    run_prog(29);
`else
    push_iss(1, 8'h01);
    push_done(1, 1);
    run_prog(9);
`endif
    // abort and start together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_fetch", imem_en, 0);
    tick();
    // abort while ISSUE waits
    ready_delay = 100;
    fill(12'hF00);
    mem[0] = 12'h103;
    do_start();
    n = 0;
    while (!issue_valid && n < 20) begin
      tick();
      n++;
    end
    chk("abort_reached_issue", issue_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_issue_valid", issue_valid, 0);
    chk("abort_issue_busy", busy, 0);
    repeat (4) tick();
    ready_delay = 0;
    // PC wrap over 256 NOPs, then abort
    fill(12'h000);
    nf = 0;
    do_start();
    n = 0;
    while (nf < 258 && n < 700) begin
      tick();
      n++;
    end
    chk("wrap_fetches", nf >= 258, 1);
    chk("wrap_addr0", addrs[0], 0);
    chk("wrap_addr255", addrs[255], 255);
    chk("wrap_addr256", addrs[256], 0);
    chk("wrap_addr257", addrs[257], 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wrap_abort_busy", busy, 0);
    chk("wrap_abort_fetch", imem_en, 0);
    repeat (4) tick();
    // Async reset during EXEC
    done_delay = 50;
    fill(12'hF00);
    mem[0] = 12'h000; mem[1] = 12'h103;
    push_iss(1, 8'h03);
    do_start();
    n = 0;
    while (!issue_valid && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (issue_valid && n < 20) begin
      tick();
      n++;
    end
    chk("exec_busy", busy, 1);
    chk("exec_pc", imem_addr, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_imem_addr", imem_addr, 0);
    chk("async_issue_unit", issue_unit, 0);
    chk("async_issue_param", issue_param, 0);
    chk("async_issue_valid", issue_valid, 0);
    tick();
    tick();
    rst = 1'b0;
    done_delay = 3;
    repeat (3) tick();
    chk("dispatch_queue_empty", exp_unit.size(), 0);
    chk("done_queue_empty", exp_derr.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Program sequencer for the neural-burning compute core. It fetches instruction words from a synchronous instruction memory and splits each word into an opcode field and parameter fields. It then dispatches DENSE, ACT and COST operations to the execution units through a valid/ready handshake and waits for each unit's completion pulse before moving on. It sits between the host start/status interface and the dense, activation and cost units.

## Interface
- `OP_SIZE`, 4, opcode field width
- `PARAM_A`, 4, activation-type field width
- `PARAM_B`, 4, dense-type field width
- `ADDR_W`, 8, instruction address width; `PARAM_C = PARAM_A + PARAM_B`; `CODE_W = OP_SIZE + PARAM_C`

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin execution at address 0; honoured only in IDLE
- `abort`  in  1  synchronous; return to IDLE on the next edge
- `loop_count`  in  16  iteration count, loaded on accepted `start` (used only with `SEQ_LOOP_EN`)
- `imem_en`  out  1  instruction read enable
- `imem_addr`  out  ADDR_W  read address (equals `pc`)
- `imem_data`  in  CODE_W  read data, valid the cycle after `imem_en`
- `issue_valid`  out  1  dispatch request
- `issue_unit`  out  2  1=dense, 2=act, 3=cost
- `issue_param`  out  PARAM_C  zero-extended type field
- `issue_ready`  in  1  unit accepts dispatch
- `unit_done`  in  1  one-cycle completion pulse from the issued unit
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse on program end
- `err`  out  1  sticky illegal-opcode flag, cleared on accepted `start`

## Operation
- **Field split:**
  - opcode = `imem_data[CODE_W-1 -: OP_SIZE]`
  - act_type = next `PARAM_A` bits below the opcode
  - dense_type = low `PARAM_B` bits
  - cost_type = low `PARAM_C` bits
- **Opcodes:**
  - 0 NOP
  - 1 DENSE: unit 1, param dense_type
  - 2 ACT: unit 2, param act_type
  - 3 COST: unit 3, param cost_type
  - 15 HALT
  - all others illegal
- **States:** IDLE, FETCH, DECODE, ISSUE, EXEC.
  - IDLE: on `start`, set `pc`=0, clear `err`, go to FETCH.
  - FETCH: drive `imem_en`=1, `imem_addr`=`pc`; go to DECODE.
  - DECODE: latch `imem_data` into the instruction register, then branch:
    - NOP: `pc`+1, go to FETCH.
    - DENSE/ACT/COST: go to ISSUE.
    - HALT: pulse `done`, go to IDLE.
    - Illegal: set `err`, pulse `done`, go to IDLE.
  - ISSUE: hold `issue_valid`=1 with stable `issue_unit`/`issue_param` until `issue_ready`=1 is sampled; then go to EXEC.
  - EXEC: wait for `unit_done`; then `pc`+1, go to FETCH.
- `pc` is ADDR_W wide and wraps from `2^ADDR_W-1` to 0 without error.
- **Ignored inputs:**
  - `unit_done` outside EXEC.
  - `start` while `busy`.
  - `unit_done` in the same cycle the handshake completes in ISSUE; it does not complete the operation.
- **abort:**
  - Applies from any state. Next edge: IDLE, `issue_valid`=0, no `done` pulse; `err` is retained.
  - `abort` and `start` in the same IDLE cycle: `abort` wins, machine stays in IDLE.

## Timing
- **Reset values:**
  - IDLE, `pc`=0
  - `imem_en`=0, `imem_addr`=0
  - `issue_valid`=0, `issue_unit`=0, `issue_param`=0
  - `busy`=0, `done`=0, `err`=0
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Cycle costs:
  - NOP: 2 cycles.
  - Dispatched op: 2 + ISSUE wait (≥1) + EXEC wait (≥1).
  - HALT: `done` is high in the cycle after DECODE, coincident with `busy`=0.
- `start` sampled at edge N gives `imem_en`=1 in cycle N+1.
- Reset asserted mid-operation returns all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- `SEQ_LOOP_EN` defined:
  - Opcode 4 is LOOP.
  - If the loop counter ≠ 0: decrement it and set `pc` = cost_type field (low ADDR_W bits), then FETCH.
  - Otherwise: `pc`+1, then FETCH.
  - The counter loads from `loop_count` on accepted `start`. LOOP costs 2 cycles.
- `SEQ_LOOP_EN` undefined:
  - Opcode 4 is illegal (sets `err`), and the loop counter is not synthesized.

## Test plan
- **Basic program.** Program [DENSE type 3, ACT type 5, COST 0x2A, HALT], units ready immediately, `unit_done` 3 cycles after accept:
  - Expect three dispatches with (unit, param) = (1,0x03), (2,0x05), (3,0x2A).
  - Expect one `done` pulse, `err`=0, `busy` low afterwards.
- **Handshake hold.** `issue_ready` held low for 5 cycles during DENSE: `issue_valid`, `issue_unit` and `issue_param` stay stable all 5 cycles, and exactly one dispatch is accepted.
- **Illegal opcode.** Opcode 7 at address 2: `err`=1 and `done` pulses with `pc`=2. A subsequent `start` clears `err`.
- **PC wrap.** `ADDR_W`=2 and 4 NOP words: `imem_addr` reads 0,1,2,3,0,…. Then `abort` forces IDLE on the next edge with no `done` pulse.
- **Reset and spurious inputs.**
  - Async `rst` during EXEC: all outputs return to reset values before the next edge.
  - `unit_done` pulsed in IDLE or ISSUE: no state change.
- **Loop (`SEQ_LOOP_EN` only).** `loop_count`=2, program [DENSE, LOOP→0, HALT]: exactly 3 DENSE dispatches, then `done`. With the macro undefined, the same program sets `err` at address 1.
